// File: rtl/skylark_pkg.sv
// rtl/skylark_pkg.sv - shared pipeline types and forwarding helper
package skylark_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Fields the hazard logic tracks for the instruction sitting in Execute
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } ex_stage_t;

  // Fields tracked for Memory and Writeback
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } mw_stage_t;

  // MEM beats WB; x0 is hardwired zero so it is never forwarded
  function automatic fwd_sel_t fwd_select(input logic [REG_ADDR_W-1:0] rs,
                                          input mw_stage_t mem,
                                          input mw_stage_t wb);
    if (rs == '0)                          return FWD_RF;
    else if (mem.reg_write && mem.rd == rs) return FWD_MEM;
    else if (wb.reg_write && wb.rd == rs)   return FWD_WB;
    else                                   return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_shadow_reg.sv
// rtl/hazard_shadow_reg.sv - one shadow pipeline stage register with flush and enable
module hazard_shadow_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Flush inserts a bubble even when the stage is held
  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (flush) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding selects, load-use stall and branch flush control
module hazard_unit
  import skylark_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic                  is_load_d,
  input  logic                  pc_src_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e
);

  ex_stage_t dec_fields;
  ex_stage_t ex;
  mw_stage_t ex_to_mem;
  mw_stage_t mem;
  mw_stage_t wb;
  fwd_sel_t  fwd_a;
  fwd_sel_t  fwd_b;
  logic      lw_stall;
  logic      unused_wb_load;

  assign dec_fields = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                        reg_write: reg_write_d, is_load: is_load_d};
  assign ex_to_mem  = '{rd: ex.rd, reg_write: ex.reg_write, is_load: ex.is_load};

  hazard_shadow_reg #(.W($bits(ex_stage_t))) u_ex (
    .clk(clk), .reset(reset), .flush(flush_e), .en(1'b1), .d(dec_fields), .q(ex)
  );

  hazard_shadow_reg #(.W($bits(mw_stage_t))) u_mem (
    .clk(clk), .reset(reset), .flush(1'b0), .en(1'b1), .d(ex_to_mem), .q(mem)
  );

  hazard_shadow_reg #(.W($bits(mw_stage_t))) u_wb (
    .clk(clk), .reset(reset), .flush(1'b0), .en(1'b1), .d(mem), .q(wb)
  );

  // WB is_load is tracked for completeness but nothing downstream reads it
  assign unused_wb_load = wb.is_load;

  // Operand selects come straight from shadow state, no added latency
  always_comb begin
    fwd_a = fwd_select(ex.rs1, mem, wb);
    fwd_b = fwd_select(ex.rs2, mem, wb);
  end

  // A load in Execute whose result Decode needs costs one bubble
  always_comb begin
    lw_stall = ex.is_load && (ex.rd != '0) && ((ex.rd == rs1_d) || (ex.rd == rs2_d));
  end

  assign forward_a_e = fwd_a;
  assign forward_b_e = fwd_b;
  assign stall_f     = lw_stall;
  assign stall_d     = lw_stall;
  assign flush_d     = pc_src_e;
  assign flush_e     = lw_stall | pc_src_e;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset; all ports are listed below, clock and reset first.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- rs1_d, rs2_d  in  5 each  source registers of the instruction in Decode.
- rd_d  in  5  destination register of the instruction in Decode.
- reg_write_d  in  1  Decode instruction writes rd.
- is_load_d  in  1  Decode instruction is a load.
- pc_src_e  in  1  taken branch/jump resolved in Execute.
- forward_a_e, forward_b_e  out  2 each  operand-mux selects for Execute: 2'b00 register file, 2'b01 WB result, 2'b10 MEM ALU result; 2'b11 never driven.
- stall_f, stall_d  out  1 each  hold the PC and the IF/ID register.
- flush_d, flush_e  out  1 each  clear the IF/ID and ID/EX registers.

Function
REQ-002 The block SHALL keep its own shadow pipeline of (rs1, rs2, rd, reg_write, is_load) for Execute, and of (rd, reg_write, is_load) for Memory and Writeback, all clocked by clk.
REQ-003 On each edge: Execute loads the Decode fields unless flush_e=1, which loads a bubble (all fields zero); Memory loads Execute; Writeback loads Memory.
REQ-004 forward_a_e SHALL be 2'b10 when rs1_e!=0, reg_write_m=1 and rd_m==rs1_e; otherwise 2'b01 when rs1_e!=0, reg_write_w=1 and rd_w==rs1_e; otherwise 2'b00. forward_b_e uses rs2_e under the same rule.
REQ-005 MEM SHALL take priority over WB when both match; register x0 SHALL never be forwarded.
REQ-006 Forward selects SHALL be combinational from the shadow registers: zero-cycle latency relative to Execute contents.
REQ-007 lw_stall SHALL be 1 when is_load_e=1, rd_e!=0, and (rd_e==rs1_d or rd_e==rs2_d).
REQ-008 stall_f = stall_d = lw_stall; flush_e = lw_stall OR pc_src_e; flush_d = pc_src_e.
REQ-009 When lw_stall and pc_src_e are both 1, the flush SHALL win: flush_d=1, flush_e=1, stall_f=stall_d=1. The PC mux still takes the branch target.
REQ-010 A load-use stall SHALL last exactly one cycle; the consumer then gets the loaded value via WB forwarding (2'b01).
REQ-011 Back-to-back load-use pairs SHALL each stall one cycle. No stall SHALL be generated by a bubble.
REQ-012 A load whose rd is x0 SHALL cause no stall.

Reset
REQ-013 While reset=1, all shadow registers SHALL clear to zero at the clock edge.
REQ-014 After reset: forward_a_e=forward_b_e=2'b00, stall_f=stall_d=0, flush_d=0, and flush_e follows pc_src_e only.
REQ-015 Reset asserted mid-stall SHALL clear the stall on the following cycle with no residual state.

Structure
REQ-016 The forwarding-select encoding SHALL be a typedef enum fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10} in the shared package skylark_pkg. REG_ADDR_W=5 SHALL also live there.
REQ-017 The shadow stage register SHALL be one parameterised sub-module, hazard_shadow_reg (width, flush, enable), instantiated three times.
REQ-018 The block SHALL contain no latches. Outputs SHALL be derived only from the shadow state and current-cycle inputs.

Verification
REQ-019 add x5 in MEM, then sub using rs1=x5 in EX -> forward_a_e=2'b10, forward_b_e=2'b00.
REQ-020 x7 written by both MEM and WB, EX reads rs2=x7 -> forward_b_e=2'b10. Next cycle, with only WB matching -> forward_b_e=2'b01.
REQ-021 lw x3 in EX, Decode reads rs1=x3 -> one cycle of stall_f=stall_d=flush_e=1. Next EX cycle -> forward_a_e=2'b00 (bubble); consumer then gets forward_a_e=2'b01.
REQ-022 lw x3 in EX with Decode reading x3, and pc_src_e=1 in the same cycle -> flush_d=1, flush_e=1. No stall carries into the next cycle.
REQ-023 Writes to x0 in MEM/WB, EX reading rs1=rs2=x0 -> both selects 2'b00; lw x0 followed by a reader of x0 -> no stall.
REQ-024 reset=1 asserted during a load-use stall for one cycle -> all outputs at reset values next cycle, shadow registers zero.
